// File: rtl/pattern_gen_if.sv
// Pixel request/response bundle between the oled driver (master) and a pixel source (slave).
interface pattern_gen_if;
  logic       read;
  logic [5:0] row_idx;
  logic [6:0] column_idx;
  logic [7:0] data;
  logic       ack;
  logic       frame_done;

  modport master (
    output read, row_idx, column_idx,
    input  data, ack, frame_done
  );

  modport slave (
    input  read, row_idx, column_idx,
    output data, ack, frame_done
  );
endinterface

// File: rtl/pattern_gen.sv
// Test-pattern pixel source for the oled read/ack port: answers each page-byte read one cycle later,
// with mode/invert latched and horizontal scroll advanced at every frame boundary.
module pattern_gen #(
  parameter int COLUMNS      = 128,
  parameter int PAGES        = 8,
  parameter int CELL_LOG2    = 3,
  parameter int SCROLL_DIV   = 4,
  parameter int SCROLL_STEP  = 1,
  parameter int DEFAULT_MODE = 5
) (
  input  logic             clk,
  input  logic             rst,
  pattern_gen_if.slave     bus,
  input  logic [2:0]       mode_in,
  input  logic             invert_in,
  input  logic             scroll_en,
  output logic [6:0]       scroll_x
);

  localparam int FCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_CHECKER = 3'd2,
    MODE_HSTRIPE = 3'd3,
    MODE_VSTRIPE = 3'd4,
    MODE_DITHER  = 3'd5,
    MODE_RSV6    = 3'd6,
    MODE_RSV7    = 3'd7
  } mode_e;

  function automatic logic pixel_on(input logic [2:0] mode, input logic [7:0] x, input logic [8:0] y);
    logic xc;
    logic yc;
    logic on;
    xc = x[CELL_LOG2];
    yc = y[CELL_LOG2];
    case (mode_e'(mode))
      MODE_ON:      on = 1'b1;
      MODE_CHECKER: on = ~(xc ^ yc);
      MODE_HSTRIPE: on = ~yc;
      MODE_VSTRIPE: on = ~xc;
      MODE_DITHER:  on = ~(xc ^ yc) & ~(x[0] ^ y[0]);
      default:      on = 1'b0;
    endcase
    return on;
  endfunction

  // Bit b of the byte is pixel row row*8+b at the (already scrolled) column x.
  function automatic logic [7:0] pattern_byte(input logic [2:0] mode, input logic inv,
                                              input logic [7:0] x, input logic [5:0] row);
    logic [7:0] byte_v;
    for (int b = 0; b < 8; b++) begin
      byte_v[b] = pixel_on(mode, x, {row, 3'(b)});
    end
    return byte_v ^ {8{inv}};
  endfunction

  logic [7:0]     data_q, data_d;
  logic           ack_q, ack_d;
  logic           frame_done_q, frame_done_d;
  logic [6:0]     scroll_x_q, scroll_x_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]     mode_q, mode_d;
  logic           invert_q, invert_d;

  logic [7:0]     x_sum;
  logic [7:0]     x_wrap;
  logic [7:0]     step_sum;
  logic [6:0]     step_wrap;
  logic           in_range;
  logic           boundary;

  always_comb begin
    x_sum     = {1'b0, bus.column_idx} + {1'b0, scroll_x_q};
    x_wrap    = (x_sum >= 8'(COLUMNS)) ? x_sum - 8'(COLUMNS) : x_sum;
    step_sum  = {1'b0, scroll_x_q} + 8'(SCROLL_STEP);
    step_wrap = 7'((step_sum >= 8'(COLUMNS)) ? step_sum - 8'(COLUMNS) : step_sum);
    in_range  = (32'(bus.row_idx) < PAGES) && (32'(bus.column_idx) < COLUMNS);
    boundary  = bus.read && (bus.row_idx == 6'(PAGES - 1)) && (bus.column_idx == 7'(COLUMNS - 1));

    ack_d        = bus.read;
    frame_done_d = boundary;
    data_d       = data_q;
    scroll_x_d   = scroll_x_q;
    frame_cnt_d  = frame_cnt_q;
    mode_d       = mode_q;
    invert_d     = invert_q;

    // Out-of-range requests are still acknowledged, with a blank (never inverted) byte.
    if (bus.read) begin
      data_d = in_range ? pattern_byte(mode_q, invert_q, x_wrap, bus.row_idx) : 8'h00;
    end

    // The boundary byte itself was computed above with the old settings and old scroll.
    if (boundary) begin
      mode_d   = mode_in;
      invert_d = invert_in;
      if (scroll_en) begin
        if (frame_cnt_q == FCW'(SCROLL_DIV - 1)) begin
          scroll_x_d  = step_wrap;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else begin
        frame_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q       <= 8'h00;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
      scroll_x_q   <= '0;
      frame_cnt_q  <= '0;
      mode_q       <= 3'(DEFAULT_MODE);
      invert_q     <= 1'b0;
    end else begin
      data_q       <= data_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
      scroll_x_q   <= scroll_x_d;
      frame_cnt_q  <= frame_cnt_d;
      mode_q       <= mode_d;
      invert_q     <= invert_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.ack        = ack_q;
  assign bus.frame_done = frame_done_q;
  assign scroll_x       = scroll_x_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Scoreboard bench for pattern_gen: a default instance and a fast-scroll instance (DIV=1, STEP=100).
module tb_pattern_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pattern_gen_if b1 ();
  pattern_gen_if b2 ();

  logic [2:0] mode_in1, mode_in2;
  logic       invert_in1, invert_in2;
  logic       scroll_en1, scroll_en2;
  logic [6:0] scroll_x1, scroll_x2;

  pattern_gen u1 (
    .clk(clk), .rst(rst), .bus(b1.slave),
    .mode_in(mode_in1), .invert_in(invert_in1), .scroll_en(scroll_en1), .scroll_x(scroll_x1)
  );

  pattern_gen #(.SCROLL_DIV(1), .SCROLL_STEP(100), .DEFAULT_MODE(4)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave),
    .mode_in(mode_in2), .invert_in(invert_in2), .scroll_en(scroll_en2), .scroll_x(scroll_x2)
  );

  typedef struct {
    logic [7:0] d;
    logic       fd;
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every ack pops one expected response, checking data, frame_done and latency.
  always @(negedge clk) begin
    exp_t e;
    if (b1.ack === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("dut1_data", 32'(b1.data), 32'(e.d));
        check("dut1_frame_done", 32'(b1.frame_done), 32'(e.fd));
        check("dut1_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (b1.frame_done === 1'b1) begin
      check("dut1_frame_done_without_ack", 32'd1, 32'd0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b2.ack === 1'b1) begin
      if (q2.size() == 0) begin
        check("dut2_unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("dut2_data", 32'(b2.data), 32'(e.d));
        check("dut2_frame_done", 32'(b2.frame_done), 32'(e.fd));
        check("dut2_latency", 32'(cyc), 32'(e.cyc));
      end
    end else if (b2.frame_done === 1'b1) begin
      check("dut2_frame_done_without_ack", 32'd1, 32'd0);
    end
  end

  task automatic issue(input bit which, input int r, input int c, input logic [7:0] d, input logic fd);
    exp_t e;
    @(negedge clk);
    e.d   = d;
    e.fd  = fd;
    e.cyc = cyc + 1;
    if (!which) begin
      b1.read = 1'b1; b1.row_idx = 6'(r); b1.column_idx = 7'(c);
      q1.push_back(e);
    end else begin
      b2.read = 1'b1; b2.row_idx = 6'(r); b2.column_idx = 7'(c);
      q2.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    b1.read = 1'b0;
    b2.read = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b1.read = 1'b0; b1.row_idx = '0; b1.column_idx = '0;
    b2.read = 1'b0; b2.row_idx = '0; b2.column_idx = '0;
    mode_in1 = 3'd5; invert_in1 = 1'b0; scroll_en1 = 1'b0;
    mode_in2 = 3'd4; invert_in2 = 1'b0; scroll_en2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(b1.ack), 32'd0);
    check("rst_data", 32'(b1.data), 32'h00);
    check("rst_frame_done", 32'(b1.frame_done), 32'd0);
    check("rst_scroll_x", 32'(scroll_x1), 32'd0);
    rst = 1'b0;
    idle();

    // T1: defaults, legacy dither with 8-pixel cells
    issue(0, 0, 0, 8'h55, 1'b0);
    issue(0, 0, 1, 8'hAA, 1'b0);
    issue(0, 0, 8, 8'h00, 1'b0);
    issue(0, 1, 0, 8'h00, 1'b0);
    idle();

    // T4: step 100 every frame: 0 -> 100 -> 72
    issue(1, 7, 127, 8'h00, 1'b1);
    issue(1, 7, 127, 8'hFF, 1'b1);
    idle();
    check("t4_scroll_x", 32'(scroll_x2), 32'd72);
    issue(1, 0, 60, 8'hFF, 1'b0);
    idle();

    // T2: mode change takes effect only after the boundary byte
    mode_in1 = 3'd2;
    issue(0, 0, 0, 8'h55, 1'b0);
    issue(0, 7, 127, 8'hAA, 1'b1);
    issue(0, 0, 0, 8'hFF, 1'b0);
    issue(0, 1, 0, 8'h00, 1'b0);
    issue(0, 1, 8, 8'hFF, 1'b0);
    idle();

    // T3: vertical stripes, scroll advances every 4th frame
    mode_in1 = 3'd4;
    issue(0, 7, 127, 8'hFF, 1'b1);
    issue(0, 0, 7, 8'hFF, 1'b0);
    scroll_en1 = 1'b1;
    issue(0, 7, 127, 8'h00, 1'b1);
    issue(0, 7, 127, 8'h00, 1'b1);
    issue(0, 7, 127, 8'h00, 1'b1);
    idle();
    check("t3_scroll_after_3", 32'(scroll_x1), 32'd0);
    issue(0, 7, 127, 8'h00, 1'b1);
    idle();
    check("t3_scroll_after_4", 32'(scroll_x1), 32'd1);
    issue(0, 0, 7, 8'h00, 1'b0);
    scroll_en1 = 1'b0;
    issue(0, 7, 127, 8'hFF, 1'b1);
    idle();
    check("t3_scroll_hold", 32'(scroll_x1), 32'd1);

    // T5: invert + solid off, out-of-range request stays blank
    invert_in1 = 1'b1; mode_in1 = 3'd0;
    issue(0, 7, 127, 8'hFF, 1'b1);
    issue(0, 0, 0, 8'hFF, 1'b0);
    issue(0, 8, 0, 8'h00, 1'b0);
    invert_in1 = 1'b0; mode_in1 = 3'd5;
    issue(0, 7, 127, 8'hFF, 1'b1);

    // T6: back-to-back burst with scroll_x=1, then latch solid-on and reset mid-burst
    issue(0, 0, 0, 8'hAA, 1'b0);
    issue(0, 0, 1, 8'h55, 1'b0);
    issue(0, 0, 2, 8'hAA, 1'b0);
    mode_in1 = 3'd1;
    issue(0, 7, 127, 8'h00, 1'b1);
    issue(0, 0, 0, 8'hFF, 1'b0);
    mode_in1 = 3'd2;
    @(negedge clk);
    b1.read = 1'b1; b1.row_idx = 6'd0; b1.column_idx = 7'd3;
    @(posedge clk);
    #1;
    check("t6_ack_before_rst", 32'(b1.ack), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_ack", 32'(b1.ack), 32'd0);
    check("t6_rst_scroll_x", 32'(scroll_x1), 32'd0);
    check("t6_rst_data", 32'(b1.data), 32'h00);
    @(negedge clk);
    b1.read = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(0, 0, 0, 8'h55, 1'b0);
    idle();

    repeat (3) idle();
    check("dut1_pending", 32'(q1.size()), 32'd0);
    check("dut2_pending", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
